// File: rtl/pattern_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : pattern_match_controller
// Description : Run-time programmable serial bit-pattern detector with a job
//               sequencer. A job is armed by `start`, which latches the pattern,
//               the length, the overlap mode and the target count. The job then
//               scans the qualified input stream, counts matches and pulses
//               `done` when the target is reached or when it is aborted.
//
// Ports       : clk, rst       - rising-edge clock, synchronous active-high reset
//               start, abort   - job control (start in IDLE, abort in ARM/RUN)
//               cfg_pattern    - pattern, bit 0 = most recent stream bit
//               cfg_len        - pattern length (0 -> 1, >PW -> PW)
//               cfg_overlap    - 1 = overlapping matches, 0 = restart after match
//               cfg_target     - matches needed to finish, 0 = unlimited
//               in, in_valid   - serial data bit and its qualifier
//               busy           - high in ARM and RUN
//               match, done    - single-cycle event pulses
//               match_count    - saturating match counter for current/last job
//               state          - IDLE=0, ARM=1, RUN=2, DONE=3
//
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_match_controller #(
    parameter int PW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [3:0]    cfg_len,
    input  logic          cfg_overlap,
    input  logic [CW-1:0] cfg_target,
    input  logic          in,
    input  logic          in_valid,
    output logic          busy,
    output logic          match,
    output logic          done,
    output logic [CW-1:0] match_count,
    output logic [1:0]    state
);

    localparam int LW = $clog2(PW + 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_ARM  = 2'd1;
    localparam logic [1:0] C_RUN  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    // Job configuration captured at start acceptance
    logic [PW-1:0] r_pattern;
    logic [LW-1:0] r_len;
    logic          r_overlap;
    logic [CW-1:0] r_target;

    // Stream history and number of valid history bits (capped at r_len)
    logic [PW-1:0] r_hist;
    logic [LW-1:0] r_fill;

    logic [1:0]    w_state_nxt;
    logic [LW-1:0] w_len_clamped;
    logic [PW-1:0] w_hist_new;
    logic [LW:0]   w_fill_inc;
    logic [LW-1:0] w_fill_new;
    logic [PW-1:0] w_mask;
    logic          w_hit;
    logic          w_accept;
    logic          w_start_acc;
    logic [CW-1:0] w_count_inc;
    logic          w_target_hit;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_match_nxt;

    // ------------------------------------------------------------------
    // Datapath combinational terms
    // ------------------------------------------------------------------
    always_comb begin
        if (cfg_len == 4'd0) begin
            w_len_clamped = LW'(1);
        end else if (int'(cfg_len) > PW) begin
            w_len_clamped = LW'(PW);
        end else begin
            w_len_clamped = LW'(cfg_len);
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PW; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hist_new = {r_hist[PW-2:0], in};
    assign w_fill_inc = {1'b0, r_fill} + 1'b1;
    assign w_fill_new = (w_fill_inc >= {1'b0, r_len}) ? r_len : w_fill_inc[LW-1:0];

    // Fill never exceeds r_len, so "fill >= len" reduces to equality
    assign w_hit = (w_fill_new == r_len) &&
                   (((w_hist_new ^ r_pattern) & w_mask) == '0);

    // Abort wins over the data bit: the bit is dropped entirely
    assign w_accept    = (state == C_RUN) && in_valid && !abort;
    assign w_start_acc = (state == C_IDLE) && start;

    assign w_count_inc  = (match_count == '1) ? match_count : match_count + 1'b1;
    assign w_target_hit = w_accept && w_hit && (r_target != '0) &&
                          (w_count_inc == r_target);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= C_IDLE;
        end else begin
            state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = state;
        case (state)
            C_IDLE: if (start) w_state_nxt = C_ARM;
            C_ARM:  w_state_nxt = abort ? C_DONE : C_RUN;
            C_RUN:  if (abort || w_target_hit) w_state_nxt = C_DONE;
            C_DONE: w_state_nxt = C_IDLE;
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt  = (w_state_nxt == C_ARM) || (w_state_nxt == C_RUN);
        w_done_nxt  = (w_state_nxt == C_DONE);
        w_match_nxt = w_accept && w_hit;
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            match       <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
            r_pattern   <= '0;
            r_len       <= LW'(1);
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
        end else begin
            busy  <= w_busy_nxt;
            done  <= w_done_nxt;
            match <= w_match_nxt;

            if (w_start_acc) begin
                r_pattern   <= cfg_pattern;
                r_len       <= w_len_clamped;
                r_overlap   <= cfg_overlap;
                r_target    <= cfg_target;
                r_hist      <= '0;
                r_fill      <= '0;
                match_count <= '0;
            end else if (w_accept) begin
                if (w_hit) begin
                    match_count <= w_count_inc;
                end
                // Non-overlapping mode restarts the search from an empty history
                if (w_hit && !r_overlap) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= w_hist_new;
                    r_fill <= w_fill_new;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_match_controller
// Description : Directed-vector bench for pattern_match_controller. Stimulus
//               pushes the expected match/done event into a queue; an
//               independent monitor pops and compares whenever the DUT
//               raises match or done. State checks at fixed points round it out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_match_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       din;
    logic       in_valid;
    logic       busy;
    logic       match;
    logic       done;
    logic [7:0] match_count;
    logic [1:0] state;

    typedef struct {
        logic       m;
        logic       d;
        logic [7:0] cnt;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    pattern_match_controller #(.PW(8), .CW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .in          (din),
        .in_valid    (in_valid),
        .busy        (busy),
        .match       (match),
        .done        (done),
        .match_count (match_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Monitor: every match/done event must correspond to a queued expectation
    always @(negedge clk) begin
        if (match || done) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event: got match=%0d done=%0d cnt=%0d state=%0d, expected no event",
                         match, done, match_count, state);
            end else begin
                mon_e = sb.pop_front();
                if (match === mon_e.m && done === mon_e.d &&
                    match_count === mon_e.cnt && state === mon_e.st) begin
                    n_pass++;
                end else begin
                    $display("FAIL event: got match=%0d done=%0d cnt=%0d state=%0d, expected match=%0d done=%0d cnt=%0d state=%0d",
                             match, done, match_count, state,
                             mon_e.m, mon_e.d, mon_e.cnt, mon_e.st);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one valid bit; queue the event it should produce, if any
    task automatic send(input bit b, input bit em, input int ecnt, input bit ed);
        in_valid = 1'b1;
        din      = b;
        if (em || ed) sb.push_back('{m: em, d: ed, cnt: 8'(ecnt), st: (ed ? 2'd3 : 2'd2)});
        tick();
        in_valid = 1'b0;
        din      = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] p, input logic [3:0] l,
                             input bit o, input logic [7:0] t);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_target  = t;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_state", state, 1);
        chk("arm_busy", busy, 1);
        tick();
        chk("run_state", state, 2);
    endtask

    task automatic do_abort(input int cnt, input bit with_bit, input bit b);
        abort    = 1'b1;
        in_valid = with_bit;
        din      = b;
        sb.push_back('{m: 1'b0, d: 1'b1, cnt: 8'(cnt), st: 2'd3});
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        din      = 1'b0;
        tick();
        chk("abort_idle_state", state, 0);
        chk("abort_idle_busy", busy, 0);
        chk("abort_count_held", match_count, cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; din = 1'b0; in_valid = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        rst = 1'b0;
        tick();

        // Reset during RUN: job lost, no done pulse, count cleared
        start_job(8'h0B, 4'd4, 1'b1, 8'd0);
        send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_run_state", state, 0);
        chk("rst_run_busy", busy, 0);
        chk("rst_run_count", match_count, 0);
        chk("rst_run_done", done, 0);
        tick();

        // Overlap: 1011 in stream 1,0,1,1,0,1,1 -> matches at bits 4 and 7
        start_job(8'h0B, 4'd4, 1'b1, 8'd0);
        send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        send(0, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 2, 0);
        chk("ovl_busy", busy, 1);
        chk("ovl_count", match_count, 2);
        do_abort(2, 0, 0);

        // Non-overlap: same stream -> single match at bit 4
        start_job(8'h0B, 4'd4, 1'b0, 8'd0);
        send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(1, 1, 1, 0);
        send(0, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0);
        chk("novl_count", match_count, 1);
        do_abort(1, 0, 0);

        // Target completion: 110, target 2; start while in DONE is ignored
        start_job(8'h06, 4'd3, 1'b1, 8'd2);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 1, 0);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 2, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tgt_idle_state", state, 0);
        chk("tgt_idle_busy", busy, 0);
        tick();
        chk("start_in_done_ignored", state, 0);
        chk("tgt_count_held", match_count, 2);

        // Gaps do not break a partial match; abort discards a completing bit
        start_job(8'h0B, 4'd4, 1'b1, 8'd0);
        send(1, 0, 0, 0); send(0, 0, 0, 0);
        repeat (5) tick();
        send(1, 0, 0, 0); send(1, 1, 1, 0);
        send(0, 0, 0, 0); send(1, 0, 0, 0);
        do_abort(1, 1, 1);

        // cfg_len=0 acts as 1; start during RUN ignored
        start_job(8'h01, 4'd0, 1'b1, 8'd0);
        send(1, 1, 1, 0); send(0, 0, 0, 0); send(1, 1, 2, 0);
        start = 1'b1; in_valid = 1'b1; din = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("start_in_run_state", state, 2);
        chk("start_in_run_count", match_count, 2);
        do_abort(2, 0, 0);

        // cfg_len=12 acts as 8: A5 found at bit 9, target 1 completes
        start_job(8'hA5, 4'd12, 1'b1, 8'd1);
        send(1, 0, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0);
        send(0, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 0);
        send(1, 1, 1, 1);
        tick();
        chk("len_clamp_idle", state, 0);
        chk("len_clamp_count", match_count, 1);

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
